uart_rx: RTL and testbench

- UART receiver: the serial-to-parallel counterpart of the team's UART transmitter, with identical frame format and parameter set.
- Samples `i_uart_rx` at mid-bit and deserialises the data LSB first.
- Optionally checks parity, checks the stop bit, and presents one word per frame with a single-cycle valid pulse.
- Sits between the board RX pin and a FIFO or command parser in the system clock domain.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_cnt.sv | 44 ++++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART state encoding and helper functions (RX and TX).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic int unsigned baud_cycle(input int unsigned clk_mhz,
                                               input int unsigned baud);
        return (clk_mhz * 32'd1000000) / baud;
    endfunction

    // Unused upper bits must be zero so they do not disturb the reduction.
    function automatic logic parity_bit(input logic [15:0] data,
                                        input logic        ptype);
        return ptype ? (^data) : (~^data);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_cnt.sv
// ============================================================================
// Module  : uart_baud_cnt
// Brief   : Bit-period counter with mid-bit and end-of-bit strobes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_cnt #(
    parameter int unsigned CYCLE = 5208
) (
    input  logic i_clk_sys,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_mid,
    output logic o_wrap
);

    localparam logic [15:0] C_LAST = 16'(CYCLE - 1);
    localparam logic [15:0] C_MID  = 16'((CYCLE / 2) - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = 16'd0;
        if (i_en) begin
            cnt_d = (cnt_q == C_LAST) ? 16'd0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_mid  = i_en && (cnt_q == C_MID);
    assign o_wrap = i_en && (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module  : uart_rx
// Brief   : UART receiver, mid-bit sampling, LSB first, optional parity.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FRE     = 50,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PARITY_ON   = 0,
    parameter int unsigned PARITY_TYPE = 0,
    parameter int unsigned BAUD_RATE   = 9600
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst_n,
    input  logic                  i_uart_rx,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_busy
);

    localparam int unsigned C_CYCLE    = baud_cycle(CLK_FRE, BAUD_RATE);
    localparam logic [3:0]  C_LAST_BIT = 4'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic                  sync1_q, sync2_q, prev_q;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  par_pend_q, par_pend_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q, frame_err_d;

    logic                  w_mid;
    logic                  w_wrap_unused;
    logic                  w_start_edge;
    logic [DATA_WIDTH:0]   w_shift_in;

    uart_baud_cnt #(
        .CYCLE (C_CYCLE)
    ) u_baud_cnt (
        .i_clk_sys (i_clk_sys),
        .i_rst_n   (i_rst_n),
        .i_en      (state_q != IDLE),
        .o_mid     (w_mid),
        .o_wrap    (w_wrap_unused)
    );

    // A break leaves prev low, so only a fresh high-to-low transition starts a frame.
    assign w_start_edge = prev_q & ~sync2_q;
    assign w_shift_in   = {sync2_q, shift_q};

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        par_pend_d   = par_pend_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        case (state_q)
            IDLE: begin
                bit_cnt_d = 4'd0;
                if (w_start_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (w_mid) begin
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_mid) begin
                    shift_d   = w_shift_in[DATA_WIDTH:1];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == C_LAST_BIT) begin
                        bit_cnt_d = 4'd0;
                        state_d   = (PARITY_ON != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_mid) begin
                    par_pend_d = sync2_q ^ parity_bit(16'(shift_q), PARITY_TYPE != 0);
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (w_mid) begin
                    data_d       = shift_q;
                    parity_err_d = par_pend_q;
                    frame_err_d  = ~sync2_q;
                    valid_d      = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= 4'd0;
            par_pend_q   <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= i_uart_rx;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_pend_q   <= par_pend_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_parity_err = parity_err_q;
    assign o_frame_err  = frame_err_q;
    assign o_busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Directed bench for uart_rx (no-parity and even/odd-parity instances).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

    // 2 MHz / 31250 baud gives 64 clocks per bit, HALF = 32.
    localparam int BIT_NS      = 640;
    localparam int BIT_FAST_NS = 621;
    localparam int LAT_NOM     = 9 * 64 + 32 + 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       line_a = 1'b1;
    logic       line_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         fall_cyc_a = 0;
    int         first_cyc_a = 0;
    int         lat = 0;
    bit         busy_seen_a = 1'b0;
    logic [9:0] qa[$];
    logic [9:0] qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(
        .CLK_FRE(2), .DATA_WIDTH(8), .PARITY_ON(0), .PARITY_TYPE(0), .BAUD_RATE(31250)
    ) dut_a (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_uart_rx(line_a),
        .o_data(data_a), .o_data_valid(valid_a), .o_parity_err(perr_a),
        .o_frame_err(ferr_a), .o_busy(busy_a)
    );

    uart_rx #(
        .CLK_FRE(2), .DATA_WIDTH(8), .PARITY_ON(1), .PARITY_TYPE(1), .BAUD_RATE(31250)
    ) dut_b (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_uart_rx(line_b),
        .o_data(data_b), .o_data_valid(valid_b), .o_parity_err(perr_b),
        .o_frame_err(ferr_b), .o_busy(busy_b)
    );

    always @(negedge clk) begin
        if (valid_a) begin
            if (qa.size() == 0) first_cyc_a = cyc;
            qa.push_back({perr_a, ferr_a, data_a});
        end
        if (valid_b) qb.push_back({perr_b, ferr_b, data_b});
        if (busy_a) busy_seen_a = 1'b1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) line_b = v;
        else     line_a = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop, input int bit_ns);
        @(posedge clk);
        #1;
        if (!sel) fall_cyc_a = cyc;
        set_line(sel, 1'b0);
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, d[i]);
            #(bit_ns);
        end
        if (has_par) begin
            set_line(sel, par);
            #(bit_ns);
        end
        set_line(sel, stop);
        #(bit_ns);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle line after reset
        repeat (10000) @(posedge clk);
        #1;
        chk("idle_pulses", qa.size() + qb.size(), 0);
        chk("idle_busy_seen", busy_seen_a, 0);
        chk("idle_busy", {busy_a, busy_b}, 0);
        chk("idle_data", data_a, 0);
        chk("idle_valid", valid_a, 0);
        chk("idle_errs", {perr_a, ferr_a, perr_b, ferr_b}, 0);

        // Back-to-back clean frames
        qa.delete();
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, BIT_NS);
        lat = first_cyc_a - fall_cyc_a;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, BIT_NS);
        repeat (100) @(posedge clk);
        chk("clean_count", qa.size(), 2);
        chk("clean_word0", qa[0], 10'h0A5);
        chk("clean_word1", qa[1], 10'h03C);
        chk("clean_latency_window", (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1) ? 1 : 0, 1);

        // Parity: ^0x07 = 1 is the expected parity bit
        qb.delete();
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, BIT_NS);
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, BIT_NS);
        repeat (100) @(posedge clk);
        chk("par_count", qb.size(), 2);
        chk("par_good", qb[0], 10'h007);
        chk("par_bad", qb[1], 10'h207);

        // Low stop bit followed by a held break
        qa.delete();
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, BIT_NS);
        #(3 * 10 * BIT_NS);
        line_a = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        chk("break_count", qa.size(), 1);
        chk("break_word", qa[0], 10'h155);
        chk("break_busy", busy_a, 0);
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, BIT_NS);
        repeat (100) @(posedge clk);
        chk("after_break_count", qa.size(), 2);
        chk("after_break_word", qa[1], 10'h012);

        // Short low glitch
        qa.delete();
        busy_seen_a = 1'b0;
        @(posedge clk);
        #1 line_a = 1'b0;
        repeat (20) @(posedge clk);
        #1 line_a = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("glitch_busy_seen", busy_seen_a, 1);
        chk("glitch_busy_end", busy_a, 0);
        chk("glitch_pulses", qa.size(), 0);

        // Reset during the 4th data bit, then a fast frame
        qa.delete();
        fork
            send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, BIT_NS);
            begin
                #(4 * BIT_NS + BIT_NS / 2);
                rst_n = 1'b0;
                #2;
                chk("rst_async_busy", busy_a, 0);
                chk("rst_async_data", data_a, 0);
            end
        join
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(posedge clk);
        chk("rst_abort_pulses", qa.size(), 0);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, BIT_FAST_NS);
        repeat (100) @(posedge clk);
        chk("skew_count", qa.size(), 1);
        chk("skew_word", qa[0], 10'h081);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
